dmem_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter that answers the core's data-memory port (a/rd/wd/we/mode) as a

---
 rtl/dmem_uart_tx_pkg.sv | 32 +++
 rtl/dmem_uart_tx_sync_fifo.sv | 51 +++++
 rtl/dmem_uart_tx.sv | 143 ++++++++++++++
 tb/tb_dmem_uart_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_uart_tx_pkg.sv
// rtl/dmem_uart_tx_pkg.sv - shared encodings for the memory-mapped UART transmitter
package dmem_uart_tx_pkg;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

  function automatic logic [31:0] loadExtend(input logic [31:0] regVal, input logic [2:0] mode);
    case (mode)
      MODE_B:  loadExtend = {{24{regVal[7]}}, regVal[7:0]};
      MODE_H:  loadExtend = {{16{regVal[15]}}, regVal[15:0]};
      MODE_BU: loadExtend = {24'h0, regVal[7:0]};
      MODE_HU: loadExtend = {16'h0, regVal[15:0]};
      MODE_W:  loadExtend = regVal;
      default: loadExtend = regVal;
    endcase
  endfunction

endpackage

// File: rtl/dmem_uart_tx_sync_fifo.sv
// rtl/dmem_uart_tx_sync_fifo.sv - single-clock FIFO; a push into a full FIFO only lands when a pop frees a slot
module dmem_uart_tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_uart_tx.sv
// rtl/dmem_uart_tx.sv - data-memory-port responder that queues stored bytes and sends them 8N1
module dmem_uart_tx
  import dmem_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  input  logic [2:0]  mode,
  output logic [31:0] rd,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel;
  logic [1:0]    regOfs;
  logic          wrTx, wrStatus, wrDiv;
  logic          fifoPop, fifoFull, fifoEmpty;
  logic [7:0]    fifoData;
  logic [CW-1:0] fifoCount;
  logic          ovf;
  logic [15:0]   baudDiv, divEff, divLat, baudCnt;
  logic [7:0]    shifter;
  logic [2:0]    bitIdx;
  logic          bitEnd;
  logic [31:0]   statusWord, regVal;
  logic          unusedWd;
  txState_t      state, nextState;

  assign sel      = (a[31:4] == BASE_ADDR[31:4]) && (a[1:0] == 2'b00);
  assign regOfs   = a[3:2];
  assign wrTx     = we && sel && (regOfs == REG_TXDATA);
  assign wrStatus = we && sel && (regOfs == REG_STATUS);
  assign wrDiv    = we && sel && (regOfs == REG_BAUDDIV);
  assign divEff   = (baudDiv == 16'd0) ? 16'd1 : baudDiv;
  assign bitEnd   = (baudCnt == 16'd0);
  assign irq      = fifoEmpty && (state == IDLE);
  assign unusedWd = ^wd[31:16];

  dmem_uart_tx_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wrTx),
    .pushData (wd[7:0]),
    .pop      (fifoPop),
    .popData  (fifoData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf     <= 1'b0;
      baudDiv <= DIV_RESET;
    end else begin
      // a push that coincides with a pop on a full FIFO is accepted, so no overflow
      if (wrTx && fifoFull && !fifoPop) ovf <= 1'b1;
      else if (wrStatus && wd[ST_OVF]) ovf <= 1'b0;
      if (wrDiv) begin
        if (mode[1:0] == 2'b00) baudDiv[7:0] <= wd[7:0];
        else                    baudDiv      <= wd[15:0];
      end
    end
  end

  always_comb begin
    statusWord = '0;
    statusWord[ST_FULL]  = fifoFull;
    statusWord[ST_EMPTY] = fifoEmpty;
    statusWord[ST_BUSY]  = (state != IDLE);
    statusWord[ST_OVF]   = ovf;
    statusWord[8 +: CW]  = fifoCount;
    case (regOfs)
      REG_STATUS:  regVal = statusWord;
      REG_BAUDDIV: regVal = {16'h0, baudDiv};
      default:     regVal = '0;
    endcase
    rd = sel ? loadExtend(regVal, mode) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shifter <= '0;
      divLat  <= 16'd1;
      baudCnt <= '0;
      bitIdx  <= '0;
    end else begin
      state <= nextState;
      if (fifoPop) begin
        shifter <= fifoData;
        divLat  <= divEff;
        baudCnt <= divEff - 16'd1;
      end else if (state != IDLE) begin
        if (bitEnd) begin
          baudCnt <= divLat - 16'd1;
          if (state == START) bitIdx <= '0;
          if (state == DATA) begin
            shifter <= shifter >> 1;
            bitIdx  <= bitIdx + 3'd1;
          end
        end else begin
          baudCnt <= baudCnt - 16'd1;
        end
      end
    end
  end

  always_comb begin
    nextState = state;
    fifoPop   = 1'b0;
    tx        = 1'b1;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          nextState = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bitEnd) nextState = DATA;
      end
      DATA: begin
        tx = shifter[0];
        if (bitEnd && bitIdx == 3'd7) nextState = STOP;
      end
      STOP: begin
        if (bitEnd) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_uart_tx.sv
// tb/tb_dmem_uart_tx.sv - bench for dmem_uart_tx against a frame-level model
module tb_dmem_uart_tx;
  import dmem_uart_tx_pkg::*;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 8;

  logic        clk;
  logic        reset;
  logic [31:0] a, wd, rd;
  logic        we, tx, irq;
  logic [2:0]  mode;

  int nCmp = 0;
  int nBad = 0;

  // model state: byte queue, register images, and the frame on the line
  logic [7:0]  q[$];
  logic        mOvf = 1'b0;
  logic [15:0] mDiv = 16'd434;
  logic        active = 1'b0;
  int          fStart = 0;
  int          fDiv = 1;
  logic [7:0]  fByte = 8'h00;
  int          cyc = 0;

  dmem_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .wd    (wd),
    .we    (we),
    .mode  (mode),
    .rd    (rd),
    .tx    (tx),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] modelRd(input logic [31:0] addr, input logic [2:0] m,
                                          input logic [31:0] status, input logic [15:0] div);
    logic [31:0] r;
    if (addr[31:4] != BASE[31:4] || addr[1:0] != 2'b00) return 32'h0;
    case (addr[3:2])
      2'd1:    r = status;
      2'd2:    r = {16'h0, div};
      default: r = 32'h0;
    endcase
    case (m)
      3'b000:  return {{24{r[7]}}, r[7:0]};
      3'b001:  return {{16{r[15]}}, r[15:0]};
      3'b100:  return {24'h0, r[7:0]};
      3'b101:  return {16'h0, r[15:0]};
      default: return r;
    endcase
  endfunction

  always @(posedge clk) begin
    logic idleBefore, idleNow, wasFull, popNow, sel, expTx, busy;
    int k;
    logic [31:0] status;
    cyc++;
    if (!reset) begin
      q.delete();
      mOvf   = 1'b0;
      mDiv   = 16'd434;
      active = 1'b0;
    end else begin
      sel        = (a[31:4] == BASE[31:4]) && (a[1:0] == 2'b00);
      idleBefore = !active || (cyc > fStart + 10 * fDiv);
      wasFull    = (q.size() == DEPTH);
      popNow     = idleBefore && (q.size() > 0);
      if (popNow) begin
        fByte  = q.pop_front();
        fDiv   = (mDiv == 16'd0) ? 1 : int'(mDiv);
        fStart = cyc;
        active = 1'b1;
      end
      if (we && sel) begin
        case (a[3:2])
          2'd0: if (!wasFull || popNow) q.push_back(wd[7:0]); else mOvf = 1'b1;
          2'd1: if (wd[3]) mOvf = 1'b0;
          2'd2: if (mode[1:0] == 2'b00) mDiv[7:0] = wd[7:0]; else mDiv = wd[15:0];
          default: ;
        endcase
      end
    end
    #1;
    idleNow = !active || (cyc >= fStart + 10 * fDiv);
    if (idleNow) expTx = 1'b1;
    else begin
      k = (cyc - fStart) / fDiv;
      if (k == 0)      expTx = 1'b0;
      else if (k <= 8) expTx = fByte[k-1];
      else             expTx = 1'b1;
    end
    busy   = !idleNow;
    status = {16'h0, 8'(q.size()), 4'h0, mOvf, busy, (q.size() == 0), (q.size() == DEPTH)};
    check("cyc_tx", {31'h0, tx}, {31'h0, expTx});
    check("cyc_irq", {31'h0, irq}, {31'h0, idleNow && (q.size() == 0)});
    check("cyc_rd", rd, modelRd(a, mode, status, mDiv));
  end

  task automatic drv(input logic [31:0] addr, input logic [31:0] data, input logic w, input logic [2:0] m);
    @(negedge clk);
    a = addr; wd = data; we = w; mode = m;
  endtask

  task automatic storeOnce(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] m);
    drv(addr, data, 1'b1, m);
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic expectRd(input logic [31:0] addr, input logic [2:0] m, input logic [31:0] exp, input string name);
    drv(addr, 32'h0, 1'b0, m);
    #1 check(name, rd, exp);
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(irq === 1'b1) && n < limit);
    check("wait_idle_timeout", {31'h0, irq}, 32'h1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] pat;
    logic [2:0] loadModes [5];
    logic [2:0] storeModes [3];
    loadModes  = '{MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU};
    storeModes = '{MODE_B, MODE_H, MODE_W};

    reset = 1'b0; a = BASE + 32'h4; wd = 32'h0; we = 1'b1; mode = MODE_W;
    repeat (3) @(negedge clk);
    #1;
    check("rst_status", rd, 32'h0000_0002);
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h1);
    a = BASE + 32'h8;
    #1 check("rst_bauddiv", rd, 32'd434);
    @(negedge clk);
    reset = 1'b1; we = 1'b0;

    // misaligned and out-of-window accesses
    storeOnce(BASE + 32'h1, 32'h41, MODE_W);
    storeOnce(BASE + 32'h10, 32'h41, MODE_W);
    expectRd(BASE + 32'h5, MODE_W, 32'h0, "misaligned_rd");
    expectRd(BASE + 32'h14, MODE_W, 32'h0, "outside_rd");
    expectRd(BASE + 32'hC, MODE_W, 32'h0, "reserved_rd");
    expectRd(BASE + 32'h4, MODE_W, 32'h0000_0002, "no_push_status");

    // load extension
    storeOnce(BASE + 32'h8, 32'h0000_8081, MODE_W);
    expectRd(BASE + 32'h8, MODE_B, 32'hFFFF_FF81, "lb_div");
    expectRd(BASE + 32'h8, MODE_BU, 32'h0000_0081, "lbu_div");
    expectRd(BASE + 32'h8, MODE_H, 32'hFFFF_8081, "lh_div");
    expectRd(BASE + 32'h8, MODE_HU, 32'h0000_8081, "lhu_div");
    storeOnce(BASE + 32'h8, 32'hFFFF_FF12, MODE_B);
    expectRd(BASE + 32'h8, MODE_W, 32'h0000_8012, "sb_div");

    // single frame with BAUDDIV=4
    storeOnce(BASE + 32'h8, 32'h4, MODE_W);
    storeOnce(BASE, 32'h55, MODE_W);
    pat = 10'b1010101010;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk);
      #2;
      check("wave_0x55", {31'h0, tx}, {31'h0, pat[j/4]});
      if (j == 20) check("wave_irq_low", {31'h0, irq}, 32'h0);
    end
    @(posedge clk);
    #2 check("wave_irq_end", {31'h0, irq}, 32'h1);

    // overflow: ten back-to-back pushes, one popped, tenth dropped
    storeOnce(BASE + 32'h8, 32'd100, MODE_W);
    for (int i = 0; i < 10; i++) drv(BASE, 32'h30 + i, 1'b1, MODE_W);
    drv(BASE + 32'h4, 32'h0, 1'b0, MODE_W);
    #1 check("ovf_status", rd, 32'h0000_080D);
    storeOnce(BASE + 32'h4, 32'h8, MODE_W);
    expectRd(BASE + 32'h4, MODE_W, 32'h0000_0805, "ovf_cleared");

    // flush, then reset in the middle of byte 0xA5 with two more queued
    drv(BASE + 32'h4, 32'h0, 1'b0, MODE_W);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    storeOnce(BASE + 32'h8, 32'h4, MODE_W);
    drv(BASE, 32'hA5, 1'b1, MODE_W);
    drv(BASE, 32'h11, 1'b1, MODE_W);
    drv(BASE, 32'h22, 1'b1, MODE_W);
    drv(BASE + 32'h4, 32'h0, 1'b0, MODE_W);
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("bit3_before_reset", {31'h0, tx}, 32'h0);
    reset = 1'b0;
    #1;
    check("reset_tx_now", {31'h0, tx}, 32'h1);
    check("reset_irq_now", {31'h0, irq}, 32'h1);
    check("reset_status_now", rd, 32'h0000_0002);
    @(negedge clk);
    reset = 1'b1;
    repeat (60) @(posedge clk);
    #2 check("after_reset_tx", {31'h0, tx}, 32'h1);
    expectRd(BASE + 32'h4, MODE_W, 32'h0000_0002, "after_reset_status");
    expectRd(BASE + 32'h8, MODE_W, 32'd434, "after_reset_div");

    // randomized traffic checked cycle by cycle against the model
    storeOnce(BASE + 32'h8, 32'h3, MODE_W);
    for (int i = 0; i < 800; i++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: drv(BASE, $urandom, 1'b1, storeModes[$urandom_range(0, 2)]);
        3:       drv(BASE + 32'h8, $urandom_range(0, 5), 1'b1, storeModes[$urandom_range(0, 2)]);
        4:       drv(BASE + 32'h4, $urandom, 1'b1, MODE_W);
        5:       drv(BASE + $urandom_range(0, 15), $urandom, 1'b0, loadModes[$urandom_range(0, 4)]);
        6:       drv(32'h0000_1000 + $urandom_range(0, 255), $urandom, 1'b1, MODE_W);
        7:       drv(BASE + 32'h1 + $urandom_range(0, 2), $urandom, 1'b1, MODE_W);
        default: drv(BASE + 4 * $urandom_range(0, 3), 32'h0, 1'b0, loadModes[$urandom_range(0, 4)]);
      endcase
    end
    drv(BASE + 32'h4, 32'h0, 1'b0, MODE_W);
    waitIdle(20000);
    repeat (5) @(posedge clk);
    #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
